// File: rtl/cci_mpf_shim_active_req_limit_if.sv
// Request/response and backpressure bundle between the AFU-side pipeline
// and the active request limiter. The master side is the traffic source
// (AFU requests, FIU responses and backpressure); the slave side is the limiter.
interface cci_mpf_shim_active_req_limit_if;
  logic       c0_req_en;
  logic [1:0] c0_req_cl_len;
  logic       c0_rsp_en;
  logic       c1_req_en;
  logic       c1_req_sop;
  logic [1:0] c1_req_cl_len;
  logic       c1_rsp_en;
  logic       c1_rsp_packed;
  logic [1:0] c1_rsp_cl_num;
  logic       fiu_c0_almost_full;
  logic       fiu_c1_almost_full;
  logic       afu_c0_almost_full;
  logic       afu_c1_almost_full;

  modport master (
    output c0_req_en, c0_req_cl_len, c0_rsp_en,
    output c1_req_en, c1_req_sop, c1_req_cl_len,
    output c1_rsp_en, c1_rsp_packed, c1_rsp_cl_num,
    output fiu_c0_almost_full, fiu_c1_almost_full,
    input  afu_c0_almost_full, afu_c1_almost_full
  );

  modport slave (
    input  c0_req_en, c0_req_cl_len, c0_rsp_en,
    input  c1_req_en, c1_req_sop, c1_req_cl_len,
    input  c1_rsp_en, c1_rsp_packed, c1_rsp_cl_num,
    input  fiu_c0_almost_full, fiu_c1_almost_full,
    output afu_c0_almost_full, afu_c1_almost_full
  );
endinterface

// File: rtl/cci_mpf_shim_active_req_limit.sv
// Active request limiter: tracks outstanding lines per channel (c0 reads,
// c1 writes) and raises AFU almost-full when the FIU pushes back or the
// outstanding count approaches MAX_ACTIVE_REQS.

// Per-channel outstanding-line counter with saturation and sticky errors.
module cci_mpf_shim_active_req_limit_chan #(
  parameter int MAX_ACTIVE_REQS = 128,
  parameter int THRESHOLD       = 8,
  parameter int CNT_WIDTH       = $clog2(MAX_ACTIVE_REQS) + 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [2:0]           inc,
  input  logic [2:0]           dec,
  input  logic                 fiu_af,
  output logic [CNT_WIDTH-1:0] active,
  output logic                 almost_full,
  output logic                 err_ovf,
  output logic                 err_unf
);
  localparam logic [CNT_WIDTH:0]   SAT      = {1'b0, {CNT_WIDTH{1'b1}}};
  localparam logic [CNT_WIDTH-1:0] AF_LIMIT = CNT_WIDTH'(MAX_ACTIVE_REQS - THRESHOLD);

  logic [CNT_WIDTH:0]   sum;
  logic [CNT_WIDTH:0]   diff;
  logic [CNT_WIDTH-1:0] nxt;
  logic                 unf;
  logic                 ovf;

  // Net this cycle's increment and decrement one bit wider than the counter,
  // clamping to zero on underflow and to all-ones on overflow.
  always_comb begin
    sum  = {1'b0, active} + (CNT_WIDTH+1)'(inc);
    unf  = sum < (CNT_WIDTH+1)'(dec);
    diff = sum - (CNT_WIDTH+1)'(dec);
    ovf  = !unf && (diff > SAT);
    nxt  = diff[CNT_WIDTH-1:0];
    if (unf)      nxt = '0;
    else if (ovf) nxt = SAT[CNT_WIDTH-1:0];
  end

  // Register count, almost-full (from next count) and sticky error flags.
  // Almost-full resets high so the AFU stays quiet until the first edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      active      <= '0;
      almost_full <= 1'b1;
      err_ovf     <= 1'b0;
      err_unf     <= 1'b0;
    end else begin
      active      <= nxt;
      almost_full <= fiu_af | (nxt > AF_LIMIT);
      err_ovf     <= err_ovf | ovf;
      err_unf     <= err_unf | unf;
    end
  end
endmodule

module cci_mpf_shim_active_req_limit #(
  parameter int MAX_ACTIVE_REQS = 128,
  parameter int THRESHOLD       = 8,
  parameter int CNT_WIDTH       = $clog2(MAX_ACTIVE_REQS) + 1
) (
  input  logic                             clk,
  input  logic                             reset,
  cci_mpf_shim_active_req_limit_if.slave   afu,
  output logic [CNT_WIDTH-1:0]             c0_active,
  output logic [CNT_WIDTH-1:0]             c1_active,
  output logic                             err_overflow,
  output logic                             err_underflow
);
  localparam int NUM_CH = 2;

  logic [NUM_CH-1:0][2:0]           inc;
  logic [NUM_CH-1:0][2:0]           dec;
  logic [NUM_CH-1:0]                fiu_af;
  logic [NUM_CH-1:0][CNT_WIDTH-1:0] active;
  logic [NUM_CH-1:0]                af;
  logic [NUM_CH-1:0]                ovf;
  logic [NUM_CH-1:0]                unf;

  // Illegal length encoding 2 counts as 4 lines so we never under-reserve.
  function automatic logic [2:0] cl_lines(input logic [1:0] len);
    case (len)
      2'd0:    cl_lines = 3'd1;
      2'd1:    cl_lines = 3'd2;
      default: cl_lines = 3'd4;
    endcase
  endfunction

  // Per-channel line deltas. Only SOP write beats reserve lines; a packed
  // write response retires the whole packet at once.
  always_comb begin
    inc[0] = afu.c0_req_en ? cl_lines(afu.c0_req_cl_len) : 3'd0;
    dec[0] = afu.c0_rsp_en ? 3'd1 : 3'd0;
    inc[1] = (afu.c1_req_en && afu.c1_req_sop) ? cl_lines(afu.c1_req_cl_len) : 3'd0;
    dec[1] = 3'd0;
    if (afu.c1_rsp_en)
      dec[1] = afu.c1_rsp_packed ? ({1'b0, afu.c1_rsp_cl_num} + 3'd1) : 3'd1;
    fiu_af = {afu.fiu_c1_almost_full, afu.fiu_c0_almost_full};
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    cci_mpf_shim_active_req_limit_chan #(
      .MAX_ACTIVE_REQS (MAX_ACTIVE_REQS),
      .THRESHOLD       (THRESHOLD),
      .CNT_WIDTH       (CNT_WIDTH)
    ) u_chan (
      .clk         (clk),
      .reset       (reset),
      .inc         (inc[g]),
      .dec         (dec[g]),
      .fiu_af      (fiu_af[g]),
      .active      (active[g]),
      .almost_full (af[g]),
      .err_ovf     (ovf[g]),
      .err_unf     (unf[g])
    );
  end

  assign c0_active              = active[0];
  assign c1_active              = active[1];
  assign afu.afu_c0_almost_full = af[0];
  assign afu.afu_c1_almost_full = af[1];
  assign err_overflow           = |ovf;
  assign err_underflow          = |unf;
endmodule

// File: tb/tb_cci_mpf_shim_active_req_limit.sv
// Bench for the active request limiter: directed scenarios followed by
// random traffic, all checked against a line-count model of the channels.
module tb_cci_mpf_shim_active_req_limit;
  localparam int MAX = 128;
  localparam int TH  = 8;
  localparam int CW  = $clog2(MAX) + 1;
  localparam int TOP = (1 << CW) - 1;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  cci_mpf_shim_active_req_limit_if bus ();
  logic [CW-1:0] c0_active, c1_active;
  logic          err_overflow, err_underflow;

  cci_mpf_shim_active_req_limit #(
    .MAX_ACTIVE_REQS (MAX),
    .THRESHOLD       (TH),
    .CNT_WIDTH       (CW)
  ) dut (
    .clk           (clk),
    .reset         (rst),
    .afu           (bus),
    .c0_active     (c0_active),
    .c1_active     (c1_active),
    .err_overflow  (err_overflow),
    .err_underflow (err_underflow)
  );

  int chk_cnt = 0;
  int err_cnt = 0;

  // model state
  int m_act [2];
  bit m_af  [2];
  bit m_ovf, m_unf;

  task automatic chk(input string tag, input int got, input int exp);
    chk_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  function automatic int lines(input logic [1:0] len);
    return (len == 2'd0) ? 1 : (len == 2'd1) ? 2 : 4;
  endfunction

  task automatic model_reset();
    m_act[0] = 0; m_act[1] = 0;
    m_af[0]  = 1; m_af[1]  = 1;
    m_ovf = 0; m_unf = 0;
  endtask

  task automatic model_ch(input int ch, input int add, input int sub, input bit fiu);
    int n;
    n = m_act[ch] + add - sub;
    if (n < 0) begin
      n = 0; m_unf = 1;
    end else if (n > TOP) begin
      n = TOP; m_ovf = 1;
    end
    m_act[ch] = n;
    m_af[ch]  = fiu || (n > MAX - TH);
  endtask

  // Predict the state after the upcoming rising edge from the driven inputs.
  task automatic model_step();
    int a0, s0, a1, s1;
    a0 = bus.c0_req_en ? lines(bus.c0_req_cl_len) : 0;
    s0 = bus.c0_rsp_en ? 1 : 0;
    a1 = (bus.c1_req_en && bus.c1_req_sop) ? lines(bus.c1_req_cl_len) : 0;
    s1 = !bus.c1_rsp_en ? 0 : bus.c1_rsp_packed ? int'(bus.c1_rsp_cl_num) + 1 : 1;
    model_ch(0, a0, s0, bus.fiu_c0_almost_full);
    model_ch(1, a1, s1, bus.fiu_c1_almost_full);
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".c0_active"}, int'(c0_active), m_act[0]);
    chk({tag, ".c1_active"}, int'(c1_active), m_act[1]);
    chk({tag, ".c0_af"}, int'(bus.afu_c0_almost_full), int'(m_af[0]));
    chk({tag, ".c1_af"}, int'(bus.afu_c1_almost_full), int'(m_af[1]));
    chk({tag, ".ovf"}, int'(err_overflow), int'(m_ovf));
    chk({tag, ".unf"}, int'(err_underflow), int'(m_unf));
  endtask

  task automatic idle();
    bus.c0_req_en = 0; bus.c0_req_cl_len = 0; bus.c0_rsp_en = 0;
    bus.c1_req_en = 0; bus.c1_req_sop = 0; bus.c1_req_cl_len = 0;
    bus.c1_rsp_en = 0; bus.c1_rsp_packed = 0; bus.c1_rsp_cl_num = 0;
    bus.fiu_c0_almost_full = 0; bus.fiu_c1_almost_full = 0;
  endtask

  // Inputs are applied at the falling edge; outputs checked at the next one.
  task automatic step(input string tag);
    model_step();
    @(negedge clk);
    check_all(tag);
    idle();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    model_reset();
    idle();
    @(negedge clk);
    @(negedge clk);
    check_all("rst");
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    idle();
    model_reset();
    do_reset();
    step("idle");
    chk("idle_c0_af_zero", int'(bus.afu_c0_almost_full), 0);

    // fill c0 to the threshold edge
    for (int i = 0; i < 30; i++) begin
      bus.c0_req_en = 1; bus.c0_req_cl_len = 2'd3;
      step("c0fill");
    end
    chk("c0_120", int'(c0_active), 120);
    chk("c0_120_af", int'(bus.afu_c0_almost_full), 0);
    bus.c0_req_en = 1; bus.c0_req_cl_len = 2'd0;
    step("c0_121");
    chk("c0_121_af", int'(bus.afu_c0_almost_full), 1);
    bus.c0_req_en = 1; bus.c0_req_cl_len = 2'd1; bus.c0_rsp_en = 1;
    step("c0_net");
    chk("c0_122", int'(c0_active), 122);

    // 4-line write packet, packed response
    bus.c1_req_en = 1; bus.c1_req_sop = 1; bus.c1_req_cl_len = 2'd3;
    step("c1_sop");
    for (int i = 0; i < 3; i++) begin
      bus.c1_req_en = 1; bus.c1_req_sop = 0; bus.c1_req_cl_len = 2'd3;
      step("c1_beat");
    end
    chk("c1_4", int'(c1_active), 4);
    bus.c1_rsp_en = 1; bus.c1_rsp_packed = 1; bus.c1_rsp_cl_num = 2'd3;
    step("c1_packed");
    chk("c1_packed_0", int'(c1_active), 0);

    // same packet, unpacked responses
    bus.c1_req_en = 1; bus.c1_req_sop = 1; bus.c1_req_cl_len = 2'd3;
    step("c1_sop2");
    for (int i = 0; i < 4; i++) begin
      bus.c1_rsp_en = 1;
      step("c1_unpk");
      chk("c1_unpk_cnt", int'(c1_active), 3 - i);
    end

    // illegal length 2 counts as 4
    bus.c1_req_en = 1; bus.c1_req_sop = 1; bus.c1_req_cl_len = 2'd2;
    step("c1_len2");
    chk("c1_len2_4", int'(c1_active), 4);

    // asynchronous reset mid-stream
    bus.c0_req_en = 1; bus.c0_req_cl_len = 2'd3;
    #2 rst = 1'b1;
    #1;
    chk("arst_c0", int'(c0_active), 0);
    chk("arst_c1", int'(c1_active), 0);
    chk("arst_af0", int'(bus.afu_c0_almost_full), 1);
    chk("arst_af1", int'(bus.afu_c1_almost_full), 1);
    do_reset();
    step("post_rst");

    // underflow on an empty counter
    bus.c0_rsp_en = 1;
    step("unf");
    chk("unf_c0", int'(c0_active), 0);
    chk("unf_flag", int'(err_underflow), 1);
    for (int i = 0; i < 3; i++) step("unf_hold");
    chk("unf_sticky", int'(err_underflow), 1);

    // FIU backpressure on c1 only
    bus.fiu_c1_almost_full = 1;
    model_step();
    @(negedge clk);
    check_all("fiu1");
    chk("fiu1_af1", int'(bus.afu_c1_almost_full), 1);
    chk("fiu1_af0", int'(bus.afu_c0_almost_full), 0);
    idle();

    // overflow: 64 four-line writes reach 256 > 255
    for (int i = 0; i < 64; i++) begin
      bus.c1_req_en = 1; bus.c1_req_sop = 1; bus.c1_req_cl_len = 2'd3;
      step("ovf_fill");
    end
    chk("ovf_sat", int'(c1_active), TOP);
    chk("ovf_flag", int'(err_overflow), 1);

    do_reset();
    step("rnd_start");

    // random traffic
    for (int i = 0; i < 400; i++) begin
      bus.c0_req_en          = ($urandom_range(0, 1) == 1);
      bus.c0_req_cl_len      = 2'($urandom_range(0, 3));
      bus.c0_rsp_en          = ($urandom_range(0, 2) != 0);
      bus.c1_req_en          = ($urandom_range(0, 1) == 1);
      bus.c1_req_sop         = ($urandom_range(0, 1) == 1);
      bus.c1_req_cl_len      = 2'($urandom_range(0, 3));
      bus.c1_rsp_en          = ($urandom_range(0, 2) == 0);
      bus.c1_rsp_packed      = ($urandom_range(0, 1) == 1);
      bus.c1_rsp_cl_num      = 2'($urandom_range(0, 3));
      bus.fiu_c0_almost_full = ($urandom_range(0, 7) == 0);
      bus.fiu_c1_almost_full = ($urandom_range(0, 7) == 0);
      step("rnd");
    end

    $display("CHECKS %0d ERRORS %0d", chk_cnt, err_cnt);
    $finish;
  end
endmodule

// File: doc/cci_mpf_shim_active_req_limit.md
Name: cci_mpf_shim_active_req_limit

Overview:
Request-credit tracker on the AFU side of the standard MPF pipeline, directly upstream of the AFU edge. Counts outstanding cache lines per channel (c0 reads, c1 writes) from request issue to response return. Asserts AFU-facing almost-full when either the FIU reports almost-full or the outstanding count nears MAX_ACTIVE_REQS. Prevents the AFU from exceeding the MPF response-order and EOP tracking capacity.

Parameters:
MAX_ACTIVE_REQS, 128, maximum outstanding lines per channel; must match the pipeline setting.
THRESHOLD, 8, slack in lines; almost-full asserts when active > MAX_ACTIVE_REQS - THRESHOLD.
CNT_WIDTH, $clog2(MAX_ACTIVE_REQS)+1, width of the active counters.

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
c0_req_en  in  1  read request issued this cycle
c0_req_cl_len  in  2  read length: 0=1 line, 1=2 lines, 3=4 lines
c0_rsp_en  in  1  read response beat returned; each beat is 1 line
c1_req_en  in  1  write beat issued
c1_req_sop  in  1  first beat of a write packet
c1_req_cl_len  in  2  write packet length, same encoding as c0
c1_rsp_en  in  1  write response returned
c1_rsp_packed  in  1  response covers the whole packet
c1_rsp_cl_num  in  2  lines-1 covered by a packed response
fiu_c0_almost_full  in  1  FIU c0 backpressure
fiu_c1_almost_full  in  1  FIU c1 backpressure
afu_c0_almost_full  out  1  registered c0 backpressure to AFU
afu_c1_almost_full  out  1  registered c1 backpressure to AFU
c0_active  out  CNT_WIDTH  outstanding read lines
c1_active  out  CNT_WIDTH  outstanding write lines
err_overflow  out  1  sticky: counter would exceed 2^CNT_WIDTH-1
err_underflow  out  1  sticky: decrement exceeded count

Behaviour:
- Reset, asynchronous: c0_active=c1_active=0; afu_c0/c1_almost_full=1 (conservative); err_overflow=err_underflow=0.
- Length decode: 0→1, 1→2, 3→4. Illegal encoding 2 decodes as 4 (conservative). No error is flagged for it.
- c0 increment: decode(c0_req_cl_len) when c0_req_en, else 0.
- c0 decrement: 1 when c0_rsp_en, else 0.
- c1 increment: decode(c1_req_cl_len) when c1_req_en & c1_req_sop. Non-SOP beats do not count.
- c1 decrement when c1_rsp_en: c1_rsp_cl_num+1 if c1_rsp_packed, else 1.
- Update: next = active + inc - dec, computed CNT_WIDTH+1 bits wide, registered once per cycle. Simultaneous inc and dec net in the same cycle.
- Underflow (active + inc < dec): next=0; err_underflow set, held until reset.
- Overflow (active + inc - dec > 2^CNT_WIDTH-1): next saturates at 2^CNT_WIDTH-1; err_overflow set, held until reset.
- Almost-full: afu_cX_almost_full <= fiu_cX_almost_full | (nextX > MAX_ACTIVE_REQS - THRESHOLD). It is computed from the next value, so it reflects the current cycle's request one cycle later.
- Latency: counters and almost-full are both 1 cycle after the input event.
- No handshaking is owned here. Requests arriving while almost-full is asserted are still counted, since the AFU may issue up to THRESHOLD more lines.
- First edge after reset deasserts: almost-full recomputes from counters (0) and the FIU inputs.
- Channels are fully independent; no shared state.

Test Plan:
- Reset then idle, fiu almost-full=0 → cycle after reset deassert: afu_c0/c1_almost_full=0, c0_active=0, c1_active=0.
- 30 c0 requests with cl_len=3 (120 lines), no responses → c0_active=120, almost-full=0. One more 1-line request → 121, afu_c0_almost_full=1 next cycle.
- From 121: c0_req_en cl_len=1 and c0_rsp_en in the same cycle → c0_active=122 (+2-1).
- 4-line write: SOP with cl_len=3 plus 3 non-SOP beats → c1_active=4. Packed rsp, cl_num=3 → c1_active=0. Alternate case: 4 unpacked rsps decrement 4→0 one per cycle.
- c0_rsp_en with c0_active=0 → c0_active stays 0, err_underflow=1 and remains 1 until reset. Asynchronous reset mid-stream → all counters 0 immediately, almost-full=1.
- fiu_c1_almost_full=1 with c1_active=0 → afu_c1_almost_full=1 next cycle; afu_c0_almost_full unaffected.
